// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared constants and helpers for the parameterised FIFO
package param_fifo_pkg;
  localparam int FWFT_REG = 0;
  localparam int FWFT_FALL = 1;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/param_fifo_if.sv
// param_fifo_if: write/read handshake and status bundle of the FIFO
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  import param_fifo_pkg::*;
  localparam int CW = clog2(DEPTH + 1);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: DEPTH x WIDTH storage, one write port, one asynchronous read port
module param_fifo_mem import param_fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered or first-word-fall-through read
module param_fifo import param_fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT = FWFT_REG
) (
  input logic        clk,
  input logic        rst,
  param_fifo_if.slave f
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("param_fifo: levels must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             full, empty, af, ae, ovf, udf, rv, wr_acc, rd_acc;
  logic [WIDTH-1:0] head, rd_q;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  param_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(f.wr_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_comb begin
    rd_acc = f.rd_en && !empty;
    wr_acc = f.wr_en && (!full || rd_acc);
    cnt_nx = (wr_acc && !rd_acc) ? cnt + 1'b1 : (rd_acc && !wr_acc) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      af     <= AF_LEVEL == 0;
      ae     <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      rv     <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= inc(wr_ptr);
      if (rd_acc) rd_ptr <= inc(rd_ptr);
      cnt   <= cnt_nx;
      full  <= cnt_nx == CW'(DEPTH);
      empty <= cnt_nx == '0;
      af    <= cnt_nx >= CW'(AF_LEVEL);
      ae    <= cnt_nx <= CW'(AE_LEVEL);
      ovf   <= ovf | (f.wr_en && full && !rd_acc);
      udf   <= udf | (f.rd_en && empty);
      rv    <= rd_acc;
      if (rd_acc) rd_q <= head;
    end
  end
  assign f.rd_data      = (FWFT == FWFT_FALL) ? head : rd_q;
  assign f.rd_valid     = (FWFT == FWFT_FALL) ? !empty : rv;
  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = af;
  assign f.almost_empty = ae;
  assign f.count        = cnt;
  assign f.overflow     = ovf;
  assign f.underflow    = udf;
endmodule
